// File: rtl/exc_unit.sv
// rtl/exc_unit.sv - exception/interrupt sequencer: flush, CP0 entry/return, fetch redirect.
// Optional EXC_IRQ_SYNC_EN: two-flop synchronizer on the irq lines.
module exc_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  irq,
    input  logic [5:0]  irq_mask,
    input  logic        ie,
    input  logic        syscall_req,
    input  logic        eret_req,
    input  logic        ovf_req,
    input  logic [29:0] req_pc,
    output logic [2:0]  exc_cp0op,
    output logic [4:0]  exc_code,
    output logic [29:0] exc_pc,
    output logic        flush,
    output logic        stall,
    output logic        redirect,
    output logic        redirect_sel
);

    typedef enum logic [1:0] {IDLE, FLUSH, ENTER, RETURN} state_t;

    state_t      state;
    logic        exl;
    logic [5:0]  irq_q;
    logic [5:0]  pending;
    logic        irq_take;
    logic        take;
    logic [4:0]  take_code;

`ifdef EXC_IRQ_SYNC_EN
    logic [5:0] irq_s1;
    logic [5:0] irq_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1 <= 6'h00;
            irq_s2 <= 6'h00;
        end else begin
            irq_s1 <= irq;
            irq_s2 <= irq_s1;
        end
    end

    assign irq_q = irq_s2;
`else
    assign irq_q = irq;
`endif

    assign pending  = irq_q & irq_mask;
    assign irq_take = ie && !exl && (|pending);
    assign take     = ovf_req || syscall_req || irq_take;

    always_comb begin
        take_code = 5'd0;
        if (ovf_req)          take_code = 5'd12;
        else if (syscall_req) take_code = 5'd8;
    end

    // Outputs are registered: each decision shows up in the cycle after its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            exl          <= 1'b0;
            exc_code     <= 5'd0;
            exc_pc       <= 30'd0;
            exc_cp0op    <= 3'b000;
            flush        <= 1'b0;
            stall        <= 1'b0;
            redirect     <= 1'b0;
            redirect_sel <= 1'b0;
        end else begin
            exc_cp0op    <= 3'b000;
            flush        <= 1'b0;
            stall        <= 1'b0;
            redirect     <= 1'b0;
            redirect_sel <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        exc_code <= take_code;
                        exc_pc   <= req_pc;
                        state    <= FLUSH;
                        flush    <= 1'b1;
                        stall    <= 1'b1;
                    end else if (eret_req && exl) begin
                        state        <= RETURN;
                        exc_cp0op    <= 3'b100;
                        redirect     <= 1'b1;
                        redirect_sel <= 1'b1;
                        flush        <= 1'b1;
                    end
                end
                FLUSH: begin
                    state     <= ENTER;
                    exc_cp0op <= 3'b011;
                    redirect  <= 1'b1;
                end
                ENTER: begin
                    exl   <= 1'b1;
                    state <= IDLE;
                end
                RETURN: begin
                    exl   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_unit.sv
// tb/tb_exc_unit.sv - directed and random checks of exc_unit against a sequence-queue model.
module tb_exc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  irq = 6'h00;
    logic [5:0]  irq_mask = 6'h00;
    logic        ie = 1'b0;
    logic        syscall_req = 1'b0;
    logic        eret_req = 1'b0;
    logic        ovf_req = 1'b0;
    logic [29:0] req_pc = 30'd0;
    logic [2:0]  exc_cp0op;
    logic [4:0]  exc_code;
    logic [29:0] exc_pc;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic        redirect_sel;

    int checks = 0;
    int errors = 0;

    exc_unit dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .irq_mask(irq_mask), .ie(ie),
        .syscall_req(syscall_req), .eret_req(eret_req), .ovf_req(ovf_req),
        .req_pc(req_pc), .exc_cp0op(exc_cp0op), .exc_code(exc_code),
        .exc_pc(exc_pc), .flush(flush), .stall(stall), .redirect(redirect),
        .redirect_sel(redirect_sel)
    );

    always #5 clk = ~clk;

    // Output vector {cp0op, flush, stall, redirect, redirect_sel} for each visible phase.
    localparam logic [6:0] V_IDLE  = 7'b000_0_0_0_0;
    localparam logic [6:0] V_FLUSH = 7'b000_1_1_0_0;
    localparam logic [6:0] V_ENTER = 7'b011_0_0_1_0;
    localparam logic [6:0] V_RET   = 7'b100_1_0_1_1;

    logic [6:0]  exp_vec = V_IDLE;
    logic [6:0]  sched[$];
    logic [4:0]  m_code = 5'd0;
    logic [29:0] m_pc = 30'd0;
    logic        m_exl = 1'b0;
    logic [5:0]  hist[2] = '{6'h00, 6'h00};

`ifdef EXC_IRQ_SYNC_EN
    localparam int IRQ_LAT = 4;
`else
    localparam int IRQ_LAT = 2;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("outs", 64'({exc_cp0op, flush, stall, redirect, redirect_sel}), 64'(exp_vec));
        chk("exc_code", 64'(exc_code), 64'(m_code));
        chk("exc_pc", 64'(exc_pc), 64'(m_pc));
    endtask

    task automatic take(input logic [4:0] code);
        m_code  = code;
        m_pc    = req_pc;
        m_exl   = 1'b1;
        exp_vec = V_FLUSH;
        sched.push_back(V_ENTER);
        sched.push_back(V_IDLE);
    endtask

    // Predicts the outputs seen after the coming rising edge from the current inputs.
    task automatic model_step();
        logic [5:0] irq_eff;
`ifdef EXC_IRQ_SYNC_EN
        irq_eff = hist[1];
        hist[1] = hist[0];
        hist[0] = irq;
`else
        irq_eff = irq;
`endif
        if (sched.size() > 0)                             exp_vec = sched.pop_front();
        else if (ovf_req)                                 take(5'd12);
        else if (syscall_req)                             take(5'd8);
        else if (ie && !m_exl && (|(irq_eff & irq_mask))) take(5'd0);
        else if (eret_req && m_exl) begin
            exp_vec = V_RET;
            m_exl   = 1'b0;
            sched.push_back(V_IDLE);
        end else                                          exp_vec = V_IDLE;
    endtask

    task automatic step(input logic [5:0] a_irq, input logic [5:0] a_mask, input logic a_ie,
                        input logic a_sys, input logic a_eret, input logic a_ovf,
                        input logic [29:0] a_pc);
        @(negedge clk);
        check_outputs();
        irq = a_irq; irq_mask = a_mask; ie = a_ie;
        syscall_req = a_sys; eret_req = a_eret; ovf_req = a_ovf; req_pc = a_pc;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b0;
        irq = 6'h00; irq_mask = 6'h00; ie = 1'b0;
        syscall_req = 1'b0; eret_req = 1'b0; ovf_req = 1'b0; req_pc = 30'd0;
        #1;
        chk("rst_now", 64'({exc_cp0op, flush, stall, redirect, redirect_sel, exc_code, exc_pc}), 64'd0);
        exp_vec = V_IDLE; m_code = 5'd0; m_pc = 30'd0; m_exl = 1'b0;
        sched.delete();
        hist[0] = 6'h00; hist[1] = 6'h00;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        model_step();
    endtask

    initial begin
        do_reset();
        idle(1);

        // Overflow at pc 0x100: flush next cycle, CP0 entry the cycle after.
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 30'h100);
        idle(1);
        chk("ovf_flush", 64'({flush, stall}), 64'b11);
        idle(1);
        chk("ovf_enter", 64'({exc_cp0op, redirect, redirect_sel, exc_code, exc_pc}),
            64'({3'b011, 1'b1, 1'b0, 5'd12, 30'h100}));
        idle(2);
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        idle(3);

        // Simultaneous ovf, syscall and irq[0]; after ERET the held irq is taken.
        step(6'h01, 6'h01, 1'b1, 1'b1, 1'b0, 1'b1, 30'h2A);
        step(6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0);
        step(6'h01, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0);
        chk("prio_code", 64'(exc_code), 64'd12);
        for (int k = 0; k < 10; k++) step(6'h3F, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 30'h55);
        chk("exl_block", 64'({exc_cp0op, redirect}), 64'd0);
        step(6'h3F, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b0, 30'h77);
        step(6'h3F, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 30'h78);
        chk("ret_out", 64'({exc_cp0op, redirect, redirect_sel}), 64'({3'b100, 1'b1, 1'b1}));
        for (int k = 0; k < 6; k++) step(6'h3F, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 30'h99);
        chk("irq_code", 64'(exc_code), 64'd0);

        // ERET with exl clear is ignored; syscall during FLUSH is dropped.
        do_reset();
        for (int k = 0; k < 5; k++) step(6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 30'd0);
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 30'h111);
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 30'h222);
        idle(3);
        chk("drop_pc", 64'(exc_pc), 64'h111);

        // Reset during ENTER abandons the sequence.
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 30'h333);
        idle(1);
        do_reset();
        idle(5);

        // Single-cycle irq[3] pulse latency.
        step(6'h08, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0, 30'h444);
        for (int k = 0; k < IRQ_LAT; k++) step(6'h00, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0);
        chk("irq_lat", 64'(redirect), 64'd1);
        idle(4);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00, 6'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 30'($urandom));
        end
        idle(4);
        @(negedge clk);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_unit.md
EXC_UNIT -- requirements
Module: exc_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 irq  input  6  level-sensitive external interrupt lines.
REQ-004 irq_mask  input  6  per-line interrupt enable from Status IM; 1 = enabled.
REQ-005 ie  input  1  global interrupt enable.
REQ-006 syscall_req  input  1  ID stage decoded SYSCALL.
REQ-007 eret_req  input  1  ID stage decoded ERET.
REQ-008 ovf_req  input  1  EX stage arithmetic overflow.
REQ-009 req_pc  input  30  word PC of the instruction raising the current request.
REQ-010 exc_cp0op  output  3  CP0 command: 3'b000 none, 3'b011 exception entry, 3'b100 return.
REQ-011 exc_code  output  5  Cause ExcCode: 0 Int, 8 Sys, 12 Ov.
REQ-012 exc_pc  output  30  captured word PC handed to CP0 as EPC.
REQ-013 flush  output  1  squash IF/ID/EX contents.
REQ-014 stall  output  1  freeze PC and pipeline registers.
REQ-015 redirect  output  1  load new fetch PC this cycle.
REQ-016 redirect_sel  output  1  0 = handler vector, 1 = CP0 EPC.

Function
REQ-017 States SHALL be IDLE, FLUSH, ENTER, RETURN; internal flag exl marks handler-in-progress.
REQ-018 pending SHALL equal irq_q & irq_mask, where irq_q is the sampled irq (see Configuration).
REQ-019 In IDLE, priority SHALL be ovf_req > syscall_req > interrupt (ie & !exl & |pending) > eret_req.
REQ-020 A taken exception SHALL latch exc_code and exc_pc = req_pc at the sampling edge, then enter FLUSH.
REQ-021 FLUSH SHALL last exactly one cycle with flush=1, stall=1, then go to ENTER.
REQ-022 ENTER SHALL last one cycle with exc_cp0op=3'b011, redirect=1, redirect_sel=0, stall=0, then set exl=1 and go to IDLE.
REQ-023 Latency SHALL be 2 cycles from request edge to the redirect cycle.
REQ-024 eret_req in IDLE with exl=1 and no higher-priority request SHALL enter RETURN.
REQ-025 RETURN SHALL last one cycle with exc_cp0op=3'b100, redirect=1, redirect_sel=1, flush=1, then clear exl and go to IDLE.
REQ-026 eret_req with exl=0 SHALL be ignored; all outputs stay at idle values.
REQ-027 Interrupts SHALL be blocked while exl=1; ovf_req and syscall_req SHALL still be taken and overwrite exc_code/exc_pc.
REQ-028 All requests arriving in FLUSH, ENTER or RETURN SHALL be dropped; only level irq can re-trigger afterwards.
REQ-029 In IDLE, exc_cp0op, flush, stall, redirect and redirect_sel SHALL be 0; exc_code and exc_pc SHALL hold their last captured values.
REQ-030 ie or irq_mask deasserting after the interrupt is taken SHALL NOT abort the in-progress sequence.

Reset
REQ-031 rst_n=0 SHALL force the following regardless of clk: state IDLE, exl=0, exc_code=0, exc_pc=0, every other output 0, synchronizer flops 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no partial exc_cp0op pulse after release.

Configuration
REQ-033 Macro EXC_IRQ_SYNC_EN defined: irq SHALL pass through a two-flop synchronizer, giving irq_q a 2-cycle delay.
REQ-034 Macro EXC_IRQ_SYNC_EN undefined: irq_q SHALL equal irq combinationally; no synchronizer flops.

Verification
REQ-035 ovf_req=1 with req_pc=30'h100 at edge 0 -> flush at cycle 1; exc_cp0op=011, exc_code=12, exc_pc=30'h100, redirect=1, redirect_sel=0 at cycle 2.
REQ-036 ovf_req, syscall_req and irq[0] (mask 6'h01, ie=1) together -> exc_code=12; after ERET the still-high irq[0] is taken with exc_code=0.
REQ-037 exl=1, irq=6'h3F, mask=6'h3F, ie=1 for 10 cycles -> no sequence; eret_req -> RETURN with exc_cp0op=100, redirect_sel=1, then the interrupt is taken 1 cycle later.
REQ-038 eret_req with exl=0 -> all outputs 0 for 5 cycles; syscall_req during FLUSH -> dropped, exc_code stays at first value.
REQ-039 rst_n low during ENTER -> all outputs 0 immediately; no 011 pulse after release.
REQ-040 irq[3] pulse with EXC_IRQ_SYNC_EN defined -> redirect 4 cycles after the edge; with it undefined -> 2 cycles.
